// File: rtl/mult_seq_pkg.sv
//==============================================================================
// Module      : mult_seq_pkg
// Description : Shared types and constants for the iterative shift-add
//               multiply sequencer (state encoding, default operand width).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mult_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Sequencer states; FIX is only reachable when MULT_SIGNED_EN is defined
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_seq_dp.sv
//==============================================================================
// Module      : mult_seq_dp
// Description : Multiply datapath: product register, (W+1)-bit partial-product
//               adder with carry-keeping right shift, optional sign fix-up,
//               and the HI/LO result registers.
//               Optional feature macro: MULT_SIGNED_EN (signed multiply).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_seq_dp
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             capture,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               negate;

`ifdef MULT_SIGNED_EN
    logic neg;

    // Operands are multiplied as magnitudes; the most negative value maps to
    // 2^(W-1), which is still correct when read as unsigned
    assign a_in   = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
    assign b_in   = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
    assign negate = fix & neg;
`else
    assign a_in   = op_a;
    assign b_in   = op_b;
    // The unsigned build never enters FIX, so no negation ever happens
    assign negate = fix & 1'b0;
`endif

    // Next product value: load, one shift-add step, or two's-complement fix-up
    always_comb begin
        sum   = p[0] ? ({1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                     : {1'b0, p[2*WIDTH-1:WIDTH]};
        p_nxt = p;
        if (load) begin
            p_nxt = {{WIDTH{1'b0}}, b_in};
        end else if (step) begin
            p_nxt = {sum, p[WIDTH-1:1]};
        end else if (negate) begin
            p_nxt = ~p + (2*WIDTH)'(1);
        end
    end

    // Product/multiplicand registers; HI/LO only change on the edge into DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p     <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULT_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            p <= p_nxt;
            if (load) begin
                mcand <= a_in;
`ifdef MULT_SIGNED_EN
                neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
            end
            if (capture) begin
                hi <= p_nxt[2*WIDTH-1:WIDTH];
                lo <= p_nxt[WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
//==============================================================================
// Module      : mult_sequencer
// Description : Iterative shift-add multiply sequencer owning the HI/LO
//               result registers. One partial-product step per clock, result
//               written with a one-cycle hiWrite/loWrite strobe.
//               Optional feature macro: MULT_SIGNED_EN (signed multiply).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hiWrite,
    output logic             loWrite,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             last_iter;
    logic             dp_load;
    logic             dp_step;
    logic             dp_fix;
    logic             dp_capture;

    assign last_iter = (count == CNT_W'(WIDTH - 1));
    assign dp_load   = (state == IDLE) && start;
    assign dp_step   = (state == RUN);
    assign dp_fix    = (state == FIX);

`ifdef MULT_SIGNED_EN
    assign dp_capture = dp_fix;
`else
    assign dp_capture = dp_step && last_iter;
`endif

    assign hiWrite = done;
    assign loWrite = done;

    // Control FSM with Moore-registered busy/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
`ifdef MULT_SIGNED_EN
                        state <= FIX;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end
                end
                FIX: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    mult_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (dp_load),
        .step    (dp_step),
        .fix     (dp_fix),
        .capture (dp_capture),
        .op_a    (op_a),
        .op_b    (op_b),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
//==============================================================================
// Module      : tb_mult_sequencer
// Description : Self-checking bench for mult_sequencer (WIDTH = 32), directed
//               vector table plus busy-start rejection and mid-run reset.
//               Expected values follow MULT_SIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_sequencer;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 200;
`ifdef MULT_SIGNED_EN
    localparam int SIGNED_BUILD = 1;
`else
    localparam int SIGNED_BUILD = 0;
`endif
    localparam int LAT = WIDTH + SIGNED_BUILD;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] model_hi;
    logic [WIDTH-1:0] model_lo;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hu;
        logic [31:0] lu;
        logic [31:0] hs;
        logic [31:0] ls;
    } vec_t;

    vec_t vecs [10];

    mult_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .hiWrite (hiWrite),
        .loWrite (loWrite),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One multiply from start to the end of a quiet window after done.
    // inject_k >= 0 pulses a start (4 x 4) at that RUN cycle; start_in_done
    // pulses a start (5 x 5) during the DONE cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string tag, input int inject_k,
                          input bit start_in_done, input int post_cycles);
        int k;
        int pulses;
        bit hold_bad;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom();
        op_b  = $urandom();
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        k = 0;
        hold_bad = 1'b0;
        while (done !== 1'b1 && k < TIMEOUT) begin
            if (hi !== model_hi || lo !== model_lo) hold_bad = 1'b1;
            if (k == inject_k) begin
                start = 1'b1;
                op_a  = 32'd4;
                op_b  = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(k), 64'(LAT));
        chk({tag, " hilo_held"}, 64'(hold_bad), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        chk({tag, " hiWrite"}, 64'(hiWrite), 64'd1);
        chk({tag, " loWrite"}, 64'(loWrite), 64'd1);
        if (start_in_done) begin
            start = 1'b1;
            op_a  = 32'd5;
            op_b  = 32'd5;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " busy_cleared"}, 64'(busy), 64'd0);
        pulses = 0;
        repeat (post_cycles) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk({tag, " extra_done_pulses"}, 64'(pulses), 64'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        int k;
        int pulses;
        n_cmp    = 0;
        n_err    = 0;
        model_hi = '0;
        model_lo = '0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        reset    = 1'b1;

        //          a             b             hi unsigned   lo unsigned   hi signed     lo signed
        vecs[0] = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'h00000001};
        vecs[2] = '{32'hFFFFFFF9, 32'h00000006, 32'h00000005, 32'hFFFFFFD6, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 32'h00000012, 32'h34567800};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h00000001};
        vecs[9] = '{32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (SIGNED_BUILD != 0)
                run_op(vecs[i].a, vecs[i].b, vecs[i].hs, vecs[i].ls,
                       $sformatf("vec%0d", i), -1, 1'b0, 3);
            else
                run_op(vecs[i].a, vecs[i].b, vecs[i].hu, vecs[i].lu,
                       $sformatf("vec%0d", i), -1, 1'b0, 3);
        end

        // Busy-start rejection: start during RUN cycle 10 and during DONE
        run_op(32'd2, 32'd3, 32'd0, 32'd6, "rej_first", -1, 1'b0, 2);
        run_op(32'd7, 32'd9, 32'd0, 32'd63, "rej_7x9", 10, 1'b1, 40);

        // Reset during RUN cycle 20
        @(negedge clk);
        op_a  = 32'h00001234;
        op_b  = 32'h00000010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("midrst busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midrst no_done", 64'(pulses), 64'd0);
        chk("midrst lo_still_zero", 64'(lo), 64'd0);
        run_op(32'd2, 32'd2, 32'd0, 32'd4, "after_rst", -1, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
